// File: rtl/mby_igr_pkg.sv
// Shared ingress types for the shim-to-packet-buffer write path:
// the segment format, the port count, and helpers to decode lane valids.
package mby_igr_pkg;

    localparam int IGR_PB_ARB_NPORT = 4;
    localparam int IGR_PB_ARB_NLANE = 3;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  ecc;
    } data64_w_ecc_t;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [7:0]  len;
        logic [13:0] flow_id;
    } epl_md_t;

    typedef struct packed {
        data64_w_ecc_t [0:7] data;
        epl_md_t             md;
    } shim_seg_t;

    // Lane valids must fill from lane 0 upward; holes are illegal.
    function automatic logic seg_v_contig(input logic [2:0] v);
        logic ok;
        case (v)
            3'b000, 3'b001, 3'b011, 3'b111: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Number of valid lanes presented in one cycle (0..3).
    function automatic logic [1:0] seg_v_count(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/igr_pb_arb_fifo.sv
// Per-port segment FIFO: accepts 0..3 segments per cycle in lane order and
// releases at most one. A cycle whose segments do not all fit, or whose lane
// valids are non-contiguous, is dropped whole and flagged.
import mby_igr_pkg::*;

module igr_pb_arb_fifo #(
    parameter int DEPTH = 8
) (
    input  logic            cclk,
    input  logic            rst,
    input  shim_seg_t [0:2] i_seg,
    input  logic [2:0]      i_seg_v,
    input  logic            i_pop,
    input  logic            i_ovf_clr,
    output shim_seg_t       o_head,
    output logic            o_empty,
    output logic            o_ovf,
    output logic            o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW:0] DEPTH_V = DEPTH[PW:0];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_ovf;
    logic          r_drop;
    shim_seg_t     r_mem [DEPTH];

    logic [PW-1:0] w_count;
    logic [PW:0]   w_free;
    logic [PW:0]   w_n_ext;
    logic [1:0]    w_n;
    logic          w_contig;
    logic          w_empty;
    logic          w_pop;
    logic          w_ovf_evt;
    logic          w_accept;
    logic [AW-1:0] w_wr_idx [3];

    // Occupancy, space check (counting a same-cycle pop) and lane write slots.
    always_comb begin
        w_contig  = seg_v_contig(i_seg_v);
        w_n       = seg_v_count(i_seg_v);
        w_empty   = (r_wr_ptr == r_rd_ptr);
        w_pop     = i_pop && !w_empty;
        w_count   = r_wr_ptr - r_rd_ptr;
        w_free    = DEPTH_V - {1'b0, w_count} + {{PW{1'b0}}, w_pop};
        w_n_ext   = {{(PW-1){1'b0}}, w_n};
        w_ovf_evt = !w_contig || (w_n_ext > w_free);
        w_accept  = !w_ovf_evt;
        for (int k = 0; k < 3; k++) begin
            w_wr_idx[k] = AW'(r_wr_ptr + PW'(k));
        end
    end

    // Pointer, sticky overflow and drop-pulse registers.
    always_ff @(posedge cclk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + (w_accept ? {{(PW-2){1'b0}}, w_n} : {PW{1'b0}});
            r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, w_pop};
            r_drop   <= w_ovf_evt;
            // A new overflow beats a simultaneous clear.
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end else begin
                r_ovf <= r_ovf;
            end
        end
    end

    // Segment storage; contents need no reset because pointers gate them.
    always_ff @(posedge cclk) begin
        for (int k = 0; k < 3; k++) begin
            if (w_accept && i_seg_v[k]) begin
                r_mem[w_wr_idx[k]] <= i_seg[k];
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = w_empty;
    assign o_ovf   = r_ovf;
    assign o_drop  = r_drop;

endmodule

// File: rtl/igr_pb_wr_arb.sv
// Packet-buffer write arbiter: four per-port segment FIFOs drained one
// segment per cycle through a single output register, round-robin over
// non-empty ports starting after the last granted port.
import mby_igr_pkg::*;

module igr_pb_wr_arb #(
    parameter int DEPTH = 8
) (
    input  logic                 cclk,
    input  logic                 rst,
    input  shim_seg_t [0:3][0:2] i_seg,
    input  logic [0:3][2:0]      i_seg_v,
    input  logic                 i_pb_ready,
    output logic                 o_pb_v,
    output shim_seg_t            o_pb_seg,
    output logic [1:0]           o_pb_port,
    input  logic [3:0]           i_ovf_clr,
    output logic [3:0]           o_ovf,
    output logic [3:0]           o_drop,
    output logic [3:0]           o_fifo_empty
);

    localparam int NPORT = IGR_PB_ARB_NPORT;

    logic            r_pb_v;
    shim_seg_t       r_pb_seg;
    logic [1:0]      r_pb_port;
    logic [1:0]      r_rr_ptr;

    shim_seg_t       w_fifo_head [NPORT];
    logic [NPORT-1:0] w_empty;
    logic [NPORT-1:0] w_pop;
    logic            w_gnt_v;
    logic [1:0]      w_gnt;
    logic [1:0]      w_idx;
    logic            w_load;

    for (genvar p = 0; p < NPORT; p++) begin : g_fifo
        igr_pb_arb_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .cclk      (cclk),
            .rst       (rst),
            .i_seg     (i_seg[p]),
            .i_seg_v   (i_seg_v[p]),
            .i_pop     (w_pop[p]),
            .i_ovf_clr (i_ovf_clr[p]),
            .o_head    (w_fifo_head[p]),
            .o_empty   (w_empty[p]),
            .o_ovf     (o_ovf[p]),
            .o_drop    (o_drop[p])
        );
    end

    // Round-robin search from r_rr_ptr; load only when the output slot frees.
    always_comb begin
        w_gnt_v = 1'b0;
        w_gnt   = r_rr_ptr;
        w_idx   = 2'd0;
        for (int i = 0; i < NPORT; i++) begin
            w_idx = r_rr_ptr + 2'(i);
            if (!w_gnt_v && !w_empty[w_idx]) begin
                w_gnt_v = 1'b1;
                w_gnt   = w_idx;
            end else begin
                w_gnt_v = w_gnt_v;
            end
        end
        w_load = (!r_pb_v || i_pb_ready) && w_gnt_v;
    end

    // Pop strobe goes only to the granted FIFO, only on a load.
    always_comb begin
        w_pop = '0;
        for (int p = 0; p < NPORT; p++) begin
            w_pop[p] = w_load && (w_gnt == 2'(p));
        end
    end

    // Output valid/port and RR pointer; the pointer moves only on a load.
    always_ff @(posedge cclk) begin
        if (rst) begin
            r_pb_v    <= 1'b0;
            r_pb_port <= 2'd0;
            r_rr_ptr  <= 2'd0;
        end else if (w_load) begin
            r_pb_v    <= 1'b1;
            r_pb_port <= w_gnt;
            r_rr_ptr  <= w_gnt + 2'd1;
        end else if (i_pb_ready) begin
            r_pb_v    <= 1'b0;
        end
    end

    // Output segment payload; meaningful only while r_pb_v is set.
    always_ff @(posedge cclk) begin
        if (w_load) begin
            r_pb_seg <= w_fifo_head[w_gnt];
        end
    end

    assign o_pb_v       = r_pb_v;
    assign o_pb_seg     = r_pb_seg;
    assign o_pb_port    = r_pb_port;
    assign o_fifo_empty = w_empty;

endmodule

// File: doc/igr_pb_wr_arb.md
IGR_PB_WR_ARB -- requirements
Module: igr_pb_wr_arb

Interface
REQ-001 Parameter DEPTH, default 8: entries per logical-port segment FIFO; power of two, minimum 4.
REQ-002 cclk  input  1  core clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_seg  input  [0:3][0:2] shim_seg_t  per-port segment lanes 0..2 from the four shim segment builders.
REQ-005 i_seg_v  input  [0:3][2:0]  per-port lane valids; bit k qualifies lane k.
REQ-006 i_pb_ready  input  1  packet buffer accepts o_pb_seg this cycle.
REQ-007 o_pb_v  output  1  o_pb_seg/o_pb_port valid.
REQ-008 o_pb_seg  output  shim_seg_t  segment presented to PB write.
REQ-009 o_pb_port  output  2  logical port of o_pb_seg.
REQ-010 i_ovf_clr  input  4  per-port clear of the sticky overflow flag.
REQ-011 o_ovf  output  4  per-port sticky overflow flag.
REQ-012 o_drop  output  4  one-cycle pulse per port when input segments are dropped.
REQ-013 o_fifo_empty  output  4  per-port FIFO empty status.

Function
REQ-014 Each port SHALL own one FIFO of DEPTH shim_seg_t entries; per cycle it SHALL accept 0..3 segments and release at most 1.
REQ-015 Valid lanes SHALL be contiguous from lane 0 (3'b000, 001, 011, 111); push order SHALL be lane 0, 1, 2.
REQ-016 Non-contiguous i_seg_v SHALL be treated as overflow: all lanes dropped, o_drop and o_ovf set.
REQ-017 Push count n = popcount(i_seg_v); free space SHALL include the entry popped in the same cycle.
REQ-018 If n > free space, all n segments of that cycle SHALL be dropped (no partial push), o_drop[p] pulses the next cycle, o_ovf[p] sets.
REQ-019 o_ovf[p] SHALL hold until i_ovf_clr[p]; a set event in the same cycle as a clear SHALL win.
REQ-020 Pointers SHALL be log2(DEPTH)+1 bits; full = MSB differs and LSBs equal; empty = pointers equal; wrap SHALL be modulo 2*DEPTH.
REQ-021 Output stage SHALL be a single register; it loads when (!o_pb_v || i_pb_ready) and at least one FIFO is non-empty.
REQ-022 Arbitration SHALL be round-robin over non-empty FIFOs, starting at the port after the last granted port; after reset the search starts at port 0.
REQ-023 The round-robin pointer SHALL advance only when a grant loads the output register.
REQ-024 While o_pb_v=1 and i_pb_ready=0, o_pb_seg, o_pb_port and o_pb_v SHALL hold stable and no FIFO pops.
REQ-025 Latency: a segment pushed into an empty FIFO while the output is idle and no other port is non-empty SHALL appear on o_pb_v two cycles after its input cycle.
REQ-026 Sustained throughput SHALL be one segment per cycle while i_pb_ready=1.
REQ-027 Order within a port SHALL be preserved; interleaving across ports is permitted.

Reset
REQ-028 While rst=1, all FIFO pointers, the RR pointer, o_pb_v, o_ovf and o_drop SHALL be cleared, and o_fifo_empty SHALL be 4'hF.
REQ-029 Reset asserted mid-operation SHALL discard buffered and in-flight segments; o_pb_seg contents are don't-care while o_pb_v=0.
REQ-030 The cycle after rst deasserts, inputs SHALL be accepted normally.

Structure
REQ-031 shim_seg_t (data64_w_ecc_t [0:7] plus epl_md_t) and IGR_PB_ARB_NPORT=4 SHALL be defined in mby_igr_pkg.
REQ-032 Per-port storage SHALL be a sub-module igr_pb_arb_fifo (3-in/1-out, parameter DEPTH), instantiated four times; arbitration and output register SHALL be in igr_pb_wr_arb.

Verification
REQ-033 Single port: port 2 pushes 3'b111 once with i_pb_ready=1 -> o_pb_port=2 on three consecutive cycles starting two cycles later, in lane order 0,1,2.
REQ-034 Round-robin: all ports push 3'b001 in the same cycle -> grants in order 0,1,2,3; then repeat -> order 0,1,2,3 again.
REQ-035 Backpressure: i_pb_ready=0 for 5 cycles with o_pb_v=1 -> outputs stable and no pops; release -> no loss or duplication.
REQ-036 Overflow: DEPTH=8 with port 1 holding 7 entries and no pop -> push 3'b011, then o_drop[1] pulses once, o_ovf[1]=1, and the FIFO still holds 7 entries.
REQ-037 Overflow clear: i_ovf_clr[1] together with a new overflow -> o_ovf[1] stays 1; a clear alone -> 0.
REQ-038 Reset mid-stream: assert rst with all FIFOs non-empty -> next cycle o_pb_v=0 and o_fifo_empty=4'hF.
